// File: rtl/kterm_seq_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : kterm_seq_gen_if
// Description : Control/result bundle of the k-term sequence generator.
//               The master drives the request; the slave (generator)
//               returns the result and the streamed terms.
// Revision    : 1.0 - initial release
// ============================================================================
interface kterm_seq_gen_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int ORDER_WIDTH = 16,
  parameter int MAX_TERMS   = 4,
  parameter int TERMS_W     = $clog2(MAX_TERMS + 1)
);
  logic                   clear;
  logic                   load;
  logic [DATA_WIDTH-1:0]  data_in;
  logic [ORDER_WIDTH-1:0] order;
  logic [TERMS_W-1:0]     terms;
  logic                   wrap;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   done;
  logic                   busy;
  logic                   overflw;
  logic                   error;
  logic                   term_valid;
  logic [DATA_WIDTH-1:0]  term_out;

  modport master (
    output clear, load, data_in, order, terms, wrap,
    input  data_out, done, busy, overflw, error, term_valid, term_out
  );

  modport slave (
    input  clear, load, data_in, order, terms, wrap,
    output data_out, done, busy, overflw, error, term_valid, term_out
  );
endinterface
`default_nettype wire

// File: rtl/kterm_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : kterm_seq_gen
// Description : k-term additive sequence generator. From a seed it walks
//               F(n) = F(n-1) + ... + F(n-k) up to F(order), streaming each
//               new term, with stop-or-wrap overflow handling.
// Revision    : 1.0 - initial release
// ============================================================================
module kterm_seq_gen #(
  parameter int DATA_WIDTH  = 64,
  parameter int ORDER_WIDTH = 16,
  parameter int MAX_TERMS   = 4,
  parameter int TERMS_W     = $clog2(MAX_TERMS + 1)
) (
  input wire logic        clk,
  input wire logic        reset,
  kterm_seq_gen_if.slave  bus
);

  // Extra headroom bits so the true sum of up to MAX_TERMS terms is exact.
  localparam int SUM_W = DATA_WIDTH + $clog2(MAX_TERMS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t                 state;
  // window[0] is the newest term F(idx), window[i] is F(idx-i).
  logic [DATA_WIDTH-1:0]  window [MAX_TERMS];
  logic [TERMS_W-1:0]     k_lat;
  logic [ORDER_WIDTH-1:0] order_lat;
  logic                   wrap_lat;
  logic [ORDER_WIDTH-1:0] idx;

  logic [SUM_W-1:0]       sum;
  logic                   sum_ovf;
  logic                   terms_ok;
  logic [ORDER_WIDTH-1:0] k_in_ext;
  logic                   short_order;
  logic [DATA_WIDTH-1:0]  seed_term;
  logic [ORDER_WIDTH-1:0] idx_next;

  // Next term: sum of the k newest window entries; older entries are masked.
  always_comb begin
    sum = '0;
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (i < int'(k_lat)) begin
        sum = sum + SUM_W'(window[i]);
      end
    end
  end

  // Request decode and overflow detection.
  always_comb begin
    sum_ovf     = |sum[SUM_W-1:DATA_WIDTH];
    terms_ok    = (bus.terms >= TERMS_W'(2)) && (bus.terms <= TERMS_W'(MAX_TERMS));
    k_in_ext    = ORDER_WIDTH'(bus.terms);
    short_order = (bus.order < k_in_ext);
    // Only F(k-1) is non-zero among the seeds.
    seed_term   = (bus.order == (k_in_ext - ORDER_WIDTH'(1))) ? bus.data_in : '0;
    idx_next    = idx + ORDER_WIDTH'(1);
  end

  // Control FSM, term window and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      k_lat          <= '0;
      order_lat      <= '0;
      wrap_lat       <= 1'b0;
      idx            <= '0;
      for (int i = 0; i < MAX_TERMS; i++) window[i] <= '0;
      bus.data_out   <= '0;
      bus.term_out   <= '0;
      bus.done       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.overflw    <= 1'b0;
      bus.error      <= 1'b0;
      bus.term_valid <= 1'b0;
    end else begin
      bus.term_valid <= 1'b0;
      if (bus.clear) begin
        state        <= IDLE;
        idx          <= '0;
        for (int i = 0; i < MAX_TERMS; i++) window[i] <= '0;
        bus.data_out <= '0;
        bus.term_out <= '0;
        bus.done     <= 1'b0;
        bus.busy     <= 1'b0;
        bus.overflw  <= 1'b0;
        bus.error    <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (bus.load) begin
              bus.overflw <= 1'b0;
              if (!terms_ok) begin
                state        <= ERR;
                bus.error    <= 1'b1;
                bus.done     <= 1'b0;
                bus.data_out <= '0;
              end else begin
                k_lat     <= bus.terms;
                order_lat <= bus.order;
                wrap_lat  <= bus.wrap;
                idx       <= k_in_ext - ORDER_WIDTH'(1);
                window[0] <= bus.data_in;
                for (int i = 1; i < MAX_TERMS; i++) window[i] <= '0;
                if (short_order) begin
                  state        <= DONE;
                  bus.done     <= 1'b1;
                  bus.data_out <= seed_term;
                end else begin
                  state        <= RUN;
                  bus.done     <= 1'b0;
                  bus.busy     <= 1'b1;
                  bus.data_out <= '0;
                end
              end
            end
          end
          RUN: begin
            if (sum_ovf && !wrap_lat) begin
              // Stop: report the last term that still fits.
              state        <= DONE;
              bus.busy     <= 1'b0;
              bus.done     <= 1'b1;
              bus.overflw  <= 1'b1;
              bus.data_out <= window[0];
            end else begin
              window[0] <= sum[DATA_WIDTH-1:0];
              for (int i = 1; i < MAX_TERMS; i++) window[i] <= window[i-1];
              idx            <= idx_next;
              bus.term_valid <= 1'b1;
              bus.term_out   <= sum[DATA_WIDTH-1:0];
              if (sum_ovf) bus.overflw <= 1'b1;
              if (idx_next == order_lat) begin
                state        <= DONE;
                bus.busy     <= 1'b0;
                bus.done     <= 1'b1;
                bus.data_out <= sum[DATA_WIDTH-1:0];
              end
            end
          end
          ERR: begin
            // Held until clear or reset.
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
